// File: rtl/hpu_rng_pkg.sv
// Shared definitions for the HPU random-number path.
//   RAND_W   : width of one generator value
//   MAX_REQ  : largest supported requester count (sizes the search function)
//   state_e  : arbiter sequencing states
//   rr_pick  : round-robin first-set search starting at a pointer
package hpu_rng_pkg;

    localparam int RAND_W  = 32;
    localparam int MAX_REQ = 16;
    localparam int IDX_W   = 4;

    typedef enum logic [1:0] {
        SEED = 2'd0,
        WARM = 2'd1,
        RUN  = 2'd2
    } state_e;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // Scan n requesters starting at ptr, ascending with wrap; first set bit wins.
    // Bits at or above n are never examined.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [IDX_W-1:0]   ptr,
                                         input int unsigned        n);
        rr_pick_t    r;
        int unsigned j;
        r.valid = 1'b0;
        r.idx   = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            j = (32'(ptr) + k) % n;
            if (k < n && !r.valid && req[j[IDX_W-1:0]]) begin
                r.valid = 1'b1;
                r.idx   = j[IDX_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rand_arbiter_if.sv
// Requester-side bus of the random arbiter.
//   reseed    : single-cycle seed reload request
//   req       : per-requester level request, held until granted
//   gnt       : one-hot grant (combinational from req and arbiter state)
//   rand_data : value delivered with the grant
//   busy      : arbiter is seeding or warming up
//   issue_cnt : values granted since the last seed load
// master = requester side, slave = arbiter side.
interface rand_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 32
);
    import hpu_rng_pkg::*;

    logic                reseed;
    logic [NUM_REQ-1:0]  req;
    logic [NUM_REQ-1:0]  gnt;
    logic [RAND_W-1:0]   rand_data;
    logic                busy;
    logic [CNT_W-1:0]    issue_cnt;

    modport master (
        output reseed, req,
        input  gnt, rand_data, busy, issue_cnt
    );

    modport slave (
        input  reseed, req,
        output gnt, rand_data, busy, issue_cnt
    );

endinterface

// File: rtl/rand_arbiter_xorshift.sv
// xorshift128 generator (Marsaglia). The output is the w word.
//   clk   : clock
//   rst_n : asynchronous active-low reset, loads the seed
//   load  : reload the seed at this edge (has priority over gen)
//   gen   : advance one step at this edge
//   value : current output, unregistered view of the w word
module rand_arbiter_xorshift
    import hpu_rng_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              gen,
    output logic [RAND_W-1:0] value
);

    localparam logic [31:0] SEED_X = 32'd123456789;
    localparam logic [31:0] SEED_Y = 32'd362436069;
    localparam logic [31:0] SEED_Z = 32'd521288629;
    localparam logic [31:0] SEED_W = 32'd88675123;

    logic [31:0] x_reg, y_reg, z_reg, w_reg;
    logic [31:0] t_mix;
    logic [31:0] w_next;

    always_comb begin
        t_mix  = x_reg ^ (x_reg << 11);
        w_next = w_reg ^ (w_reg >> 19) ^ t_mix ^ (t_mix >> 8);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg <= SEED_X;
            y_reg <= SEED_Y;
            z_reg <= SEED_Z;
            w_reg <= SEED_W;
        end else if (load) begin
            x_reg <= SEED_X;
            y_reg <= SEED_Y;
            z_reg <= SEED_Z;
            w_reg <= SEED_W;
        end else if (gen) begin
            x_reg <= y_reg;
            y_reg <= z_reg;
            z_reg <= w_reg;
            w_reg <= w_next;
        end
    end

    assign value = w_reg;

endmodule

// File: rtl/rand_arbiter.sv
// Round-robin arbiter sharing one xorshift stream among NUM_REQ requesters.
// The generator only advances when a value is granted, so every value is
// delivered exactly once.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : requester bus (reseed, req, gnt, rand_data, busy, issue_cnt)
// Parameters: NUM_REQ (2..16), WARMUP discarded steps after each seed load
// (0..255), CNT_W issued-value counter width.
module rand_arbiter
    import hpu_rng_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WARMUP  = 0,
    parameter int CNT_W   = 32
)(
    input  logic           clk,
    input  logic           rst_n,
    rand_arbiter_if.slave  bus
);

    localparam logic [1:0] ST_SEED   = SEED;
    localparam logic [1:0] ST_WARM   = WARM;
    localparam logic [1:0] ST_RUN    = RUN;
    localparam int         WARM_LAST = (WARMUP > 0) ? WARMUP - 1 : 0;

    logic [1:0]         state_reg,     state_next;
    logic [IDX_W-1:0]   rr_ptr_reg,    rr_ptr_next;
    logic [7:0]         warm_cnt_reg,  warm_cnt_next;
    logic [CNT_W-1:0]   issue_cnt_reg, issue_cnt_next;

    logic [MAX_REQ-1:0] req_ext;
    rr_pick_t           pick;
    logic               grant_any;
    logic               gen;
    logic               load;
    logic [NUM_REQ-1:0] gnt_vec;
    logic [RAND_W-1:0]  gen_value;

    // Widen req to the search function's fixed width; upper bits stay clear
    // so the search can never land outside the requester range.
    always_comb begin
        req_ext               = '0;
        req_ext[NUM_REQ-1:0]  = bus.req;
    end

    assign pick = rr_pick(req_ext, rr_ptr_reg, NUM_REQ);

    // reseed suppresses granting in the cycle it is seen.
    assign grant_any = (state_reg == ST_RUN) && !bus.reseed && pick.valid;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_gnt
            assign gnt_vec[gi] = grant_any && (pick.idx == IDX_W'(gi));
        end
    endgenerate

    // The seed is loaded on every edge spent in SEED, including a SEED
    // cycle that sees another reseed.
    assign load = (state_reg == ST_SEED);

    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        warm_cnt_next  = warm_cnt_reg;
        issue_cnt_next = issue_cnt_reg;
        gen            = 1'b0;
        if (bus.reseed) begin
            state_next = ST_SEED;
        end else begin
            case (state_reg)
                ST_SEED: begin
                    warm_cnt_next  = '0;
                    issue_cnt_next = '0;
                    state_next     = (WARMUP > 0) ? ST_WARM : ST_RUN;
                end
                ST_WARM: begin
                    gen           = 1'b1;
                    warm_cnt_next = warm_cnt_reg + 8'd1;
                    if (warm_cnt_reg == 8'(WARM_LAST)) begin
                        state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (grant_any) begin
                        gen            = 1'b1;
                        issue_cnt_next = issue_cnt_reg + 1'b1;
                        rr_ptr_next    = (pick.idx == IDX_W'(NUM_REQ - 1)) ?
                                         '0 : pick.idx + 1'b1;
                    end
                end
                default: begin
                    state_next = ST_SEED;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_SEED;
            rr_ptr_reg    <= '0;
            warm_cnt_reg  <= '0;
            issue_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            warm_cnt_reg  <= warm_cnt_next;
            issue_cnt_reg <= issue_cnt_next;
        end
    end

    rand_arbiter_xorshift u_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .gen   (gen),
        .value (gen_value)
    );

    assign bus.gnt       = gnt_vec;
    assign bus.rand_data = gen_value;
    assign bus.busy      = (state_reg != ST_RUN);
    assign bus.issue_cnt = issue_cnt_reg;

endmodule

// File: doc/rand_arbiter.md
Name: rand_arbiter

Overview:
- Owns one xorshift generator instance and shares its 32-bit output stream among NUM_REQ requesters.
- Drives the generator's gen control through a reseed, warm-up and run sequence.
- Grants one requester per cycle in round-robin order. The generator advances only when a value is consumed, so no value is ever handed out twice or skipped.
- Sits between the HPU random-hypervector consumers and the shared RNG.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- WARMUP, 0, number of generator steps discarded after each seed load before the first grant (0..255).
- CNT_W, 32, width of the issued-value counter.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- reseed  input  1  single-cycle request to reload the generator seed and restart the sequence
- req  input  NUM_REQ  per-requester request, level; held until granted
- gnt  output  NUM_REQ  one-hot grant, same cycle as req (combinational from req and state); data is valid when the requester's gnt bit is high
- rand_data  output  32  current generator value; meaningful only while any gnt bit is high
- busy  output  1  high while not in RUN (seeding or warming up)
- issue_cnt  output  CNT_W  number of values granted since the last seed load

Behaviour:
- FSM states: SEED, WARM, RUN.
- Asynchronous reset (rst_n=0) forces:
  - state=SEED, rr pointer=0, warm counter=0, issue_cnt=0;
  - gnt=0, busy=1, gen=0. While reset is held, the generator reloads its seed every edge.
- SEED:
  - gen=0 for exactly one cycle; the generator loads its seed at that edge.
  - Next state is WARM if WARMUP>0, else RUN.
  - Warm counter is cleared; issue_cnt is cleared.
- WARM:
  - gen=1 every cycle; warm counter increments.
  - On the cycle the counter equals WARMUP-1, next state is RUN.
  - gnt stays 0.
- RUN:
  - gen = |gnt; busy=0.
  - Grant search starts at rr pointer and ascends with wrap modulo NUM_REQ; the first set req bit wins.
  - On a grant to index i: rr pointer <= (i+1) mod NUM_REQ; issue_cnt increments, wrapping at 2^CNT_W.
  - With no req: gnt=0, gen=0, and the generator holds its value indefinitely.
- rand_data equals the generator's current output, unregistered. The value presented with a grant in cycle t is replaced by the next sequence value in cycle t+1.
- Throughput: one value per cycle. A single requester holding req continuously receives consecutive sequence values on consecutive cycles.
- reseed:
  - Sampled in any state and has priority over granting: in the cycle reseed=1, gnt=0 and gen=0.
  - Next state is SEED; rr pointer is preserved.
  - reseed during SEED or WARM restarts the sequence from SEED.
- Latency from reset release to first possible grant: 1 + WARMUP cycles.
- Requests raised in SEED or WARM are not dropped; they are served in RUN once req is still high.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt is only nonzero in RUN.

Decomposition:
- Shared package hpu_rng_pkg holds:
  - the state enum {SEED, WARM, RUN};
  - the RAND_W=32 constant;
  - a function for the round-robin first-set search.
- Sub-module: instantiate the existing xorshift block as the generator, with gen driven by the FSM.
- No other sub-modules; arbitration stays inline.

Test Plan:
- Reset and warm-up:
  - Stimulus: WARMUP=0, release rst_n, hold req=4'b0001 continuously.
  - Response: busy=1 for 1 cycle; then gnt=0001 each cycle with rand_data = 88675123, 3701687786, 458299110; issue_cnt=3 afterwards.
- Warm-up discard:
  - Stimulus: WARMUP=1, same request pattern.
  - Response: busy high for 2 cycles; first granted rand_data=3701687786.
- Round robin fairness:
  - Stimulus: req=4'b1111 for 8 cycles.
  - Response: gnt sequence 0001,0010,0100,1000,0001,...; each grant carries the next sequence value; no value repeated.
- Idle hold:
  - Stimulus: grant one value, then req=0 for 10 cycles, then req=0010.
  - Response: rand_data stable over the 10 idle cycles; the grant delivers exactly the next sequence value (458299110 when 3701687786 was last consumed with WARMUP=0).
- Reseed mid-run:
  - Stimulus: after 5 grants, pulse reseed while req=1111.
  - Response: gnt=0 that cycle; one SEED cycle with busy=1; issue_cnt=0; the next grant carries 88675123 and goes to the requester after the last one granted.
- Async reset mid-run:
  - Stimulus: drop rst_n between clock edges during continuous grants.
  - Response: gnt=0 and busy=1 immediately; after release the sequence restarts at 88675123 with rr pointer 0.
